// File: rtl/hazard_tracker_if.sv
// rtl/hazard_tracker_if.sv - EX-stage operand/writer bundle between pipeline control and hazard_tracker
//
// Purpose: carries the EX instruction's register usage into the hazard
// tracker and its bypass selects, stall and stall counter back out.
// Ports (master = pipeline side, slave = hazard_tracker side):
//   ex_valid, ex_rs, ex_rs_en, ex_rd, ex_we, ex_is_load, flush  -> tracker
//   fwd_sel, stall, stall_cnt                                   <- tracker

interface hazard_tracker_if #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    localparam int SW = $clog2(DEPTH + 1);

    logic                    ex_valid;
    logic [5*NUM_SRC-1:0]    ex_rs;
    logic [NUM_SRC-1:0]      ex_rs_en;
    logic [4:0]              ex_rd;
    logic                    ex_we;
    logic                    ex_is_load;
    logic                    flush;
    logic [SW*NUM_SRC-1:0]   fwd_sel;
    logic                    stall;
    logic [15:0]             stall_cnt;

    modport master (
        output ex_valid, ex_rs, ex_rs_en, ex_rd, ex_we, ex_is_load, flush,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  ex_valid, ex_rs, ex_rs_en, ex_rd, ex_we, ex_is_load, flush,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - EX-stage forwarding select and load-use interlock
//
// Purpose: tracks the writers in flight after EX in a private shift register
// and, for every source operand of the EX instruction, chooses the bypass
// stage (or the register file) and raises a single stall on load-use.
// Ports:
//   clk   - rising-edge clock
//   rstn  - synchronous active-low reset (drops all in-flight writers)
//   bus   - hazard_tracker_if.slave: EX operand/writer info and flush in,
//           fwd_sel (SW bits per operand, 0 = regfile, k = slot k),
//           stall and the saturating 16-bit stall_cnt out

module hazard_tracker #(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    hazard_tracker_if.slave  bus
);
    localparam int SW = $clog2(DEPTH + 1);

    // Slot k (1 = MEM, 2 = WB, ...) describes the writer that left EX k cycles ago.
    logic [DEPTH:1]        slot_v;
    logic [DEPTH:1]        slot_we;
    logic [DEPTH:1]        slot_ld;
    logic [4:0]            slot_rd [1:DEPTH];

    logic [NUM_SRC-1:0]    hazard;
    logic [SW*NUM_SRC-1:0] sel;
    logic                  stall;
    logic [15:0]           stall_cnt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [DEPTH:1] hit;
        logic [SW-1:0]  op_sel;
        logic           op_haz;

        for (genvar k = 1; k <= DEPTH; k++) begin : g_slot
            // x0 is hardwired zero, so a write to it is never a real producer.
            assign hit[k] = slot_v[k] & slot_we[k] & (slot_rd[k] != 5'd0) &
                            (slot_rd[k] == bus.ex_rs[5*i +: 5]) & bus.ex_rs_en[i];
        end

        // Walk from the oldest slot to the youngest so the youngest match
        // overwrites everything older. A young load that is not yet ready
        // therefore blocks any older producer of the same register.
        always_comb begin
            op_sel = '0;
            op_haz = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (hit[k]) begin
                    if (slot_ld[k] && (k <= LOAD_LAT)) begin
                        op_haz = 1'b1;
                        op_sel = '0;
                    end else begin
                        op_haz = 1'b0;
                        op_sel = SW'(k);
                    end
                end
            end
        end

        assign sel[SW*i +: SW] = op_sel;
        assign hazard[i]       = op_haz;
    end

    // A flushed or empty EX slot never needs to wait for its operands.
    assign stall = bus.ex_valid & ~bus.flush & (|hazard);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_v    <= '0;
            slot_we   <= '0;
            slot_ld   <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_rd[k] <= 5'd0;
            end
            stall_cnt <= 16'd0;
        end else begin
            // Stalled or flushed EX instructions enter MEM as a bubble; the
            // upstream stages hold, so the stalled one is presented again.
            slot_v  <= {slot_v[DEPTH-1:1],  bus.ex_valid & ~bus.flush & ~stall};
            slot_we <= {slot_we[DEPTH-1:1], bus.ex_we};
            slot_ld <= {slot_ld[DEPTH-1:1], bus.ex_is_load};
            for (int k = DEPTH; k >= 2; k--) begin
                slot_rd[k] <= slot_rd[k-1];
            end
            slot_rd[1] <= bus.ex_rd;

            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign bus.fwd_sel   = sel;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - self-checking bench for hazard_tracker

module tb_hazard_tracker;
    logic clk = 1'b0;
    logic rstn0 = 1'b0;
    logic rstn1 = 1'b0;
    logic rstn2 = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_tracker_if #(.NUM_SRC(2), .DEPTH(3)) if0 ();
    hazard_tracker_if #(.NUM_SRC(3), .DEPTH(4)) if1 ();
    hazard_tracker_if #(.NUM_SRC(1), .DEPTH(7)) if2 ();

    hazard_tracker #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(1)) u0 (.clk(clk), .rstn(rstn0), .bus(if0));
    hazard_tracker #(.NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2)) u1 (.clk(clk), .rstn(rstn1), .bus(if1));
    hazard_tracker #(.NUM_SRC(1), .DEPTH(7), .LOAD_LAT(6)) u2 (.clk(clk), .rstn(rstn2), .bus(if2));

    // Reference model: history of what entered MEM, newest first.
    typedef struct packed { bit v; bit [4:0] rd; bit we; bit ld; } ent_t;
    ent_t h0[$];
    ent_t h1[$];
    int   cnt_m[2];
    bit        in_v[2];
    bit [14:0] in_rs[2];
    bit [2:0]  in_en[2];
    bit [4:0]  in_rd[2];
    bit        in_we[2];
    bit        in_ld[2];
    bit        in_fl[2];

    function automatic void model_eval(input int inst, output bit [8:0] sel, output bit st);
        ent_t h[$];
        int   ll;
        int   ns;
        bit   haz;
        if (inst == 0) begin h = h0; ll = 1; ns = 2; end
        else begin h = h1; ll = 2; ns = 3; end
        haz = 1'b0;
        sel = '0;
        for (int i = 0; i < ns; i++) begin
            if (in_en[inst][i]) begin
                for (int k = 0; k < h.size(); k++) begin
                    if (h[k].v && h[k].we && h[k].rd != 5'd0 && h[k].rd == in_rs[inst][5*i +: 5]) begin
                        if (h[k].ld && (k + 1) <= ll) haz = 1'b1;
                        else sel[3*i +: 3] = 3'(k + 1);
                        break;
                    end
                end
            end
        end
        st = in_v[inst] & ~in_fl[inst] & haz;
    endfunction

    function automatic void model_step(input int inst, input bit r);
        bit [8:0] s;
        bit       st;
        ent_t     e;
        int       depth;
        depth = (inst == 0) ? 3 : 4;
        model_eval(inst, s, st);
        if (!r) begin
            e = '0;
            if (inst == 0) begin h0.delete(); for (int k = 0; k < depth; k++) h0.push_back(e); end
            else begin h1.delete(); for (int k = 0; k < depth; k++) h1.push_back(e); end
            cnt_m[inst] = 0;
        end else begin
            e.v = in_v[inst] & ~in_fl[inst] & ~st;
            e.rd = in_rd[inst];
            e.we = in_we[inst];
            e.ld = in_ld[inst];
            if (inst == 0) begin h0.push_front(e); if (h0.size() > depth) void'(h0.pop_back()); end
            else begin h1.push_front(e); if (h1.size() > depth) void'(h1.pop_back()); end
            if (st && cnt_m[inst] < 65535) cnt_m[inst]++;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, rstn0);
            model_step(1, rstn1);
        end
    end

    task automatic drive(input int inst, input bit v, input bit [14:0] rs, input bit [2:0] en,
                         input bit [4:0] rd, input bit we, input bit ld, input bit fl);
        in_v[inst] = v; in_rs[inst] = rs; in_en[inst] = en;
        in_rd[inst] = rd; in_we[inst] = we; in_ld[inst] = ld; in_fl[inst] = fl;
        if (inst == 0) begin
            if0.ex_valid = v; if0.ex_rs = rs[9:0]; if0.ex_rs_en = en[1:0];
            if0.ex_rd = rd; if0.ex_we = we; if0.ex_is_load = ld; if0.flush = fl;
        end else begin
            if1.ex_valid = v; if1.ex_rs = rs; if1.ex_rs_en = en;
            if1.ex_rd = rd; if1.ex_we = we; if1.ex_is_load = ld; if1.flush = fl;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn0 = 1'b0; rstn1 = 1'b0;
        drive(1, 0, '0, 0, 0, 0, 0, 0);
        drive(0, 0, '0, 0, 0, 0, 0, 0);
        tick();
        rstn0 = 1'b1; rstn1 = 1'b1;
        drive(0, 1, {5'd0, 5'd5, 5'd5}, 3'b011, 0, 0, 0, 0);
        n_checks++; if (if0.fwd_sel !== 4'd0) begin n_fail++; $display("FAIL reset_fwd: got %b expected 0000", if0.fwd_sel); end
        n_checks++; if (if0.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", if0.stall); end
        n_checks++; if (if0.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", if0.stall_cnt); end
        n_checks++; if (if1.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d expected 0", if1.stall_cnt); end
        tick();
    endtask

    task automatic test_forward();
        logic [3:0] exp_sel [4];
        exp_sel = '{4'b0101, 4'b1010, 4'b1111, 4'b0000};
        drive(0, 1, '0, 0, 5, 1, 0, 0);
        tick();
        for (int t = 0; t < 4; t++) begin
            drive(0, 1, {5'd0, 5'd5, 5'd5}, 3'b011, 0, 0, 0, 0);
            n_checks++; if (if0.fwd_sel !== exp_sel[t]) begin n_fail++; $display("FAIL fwd_age%0d: got %b expected %b", t + 1, if0.fwd_sel, exp_sel[t]); end
            n_checks++; if (if0.stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall%0d: got %b expected 0", t + 1, if0.stall); end
            tick();
        end
    endtask

    task automatic test_load_use();
        drive(0, 1, '0, 0, 6, 1, 1, 0);
        tick();
        drive(0, 1, {5'd0, 5'd6, 5'd0}, 3'b010, 0, 0, 0, 0);
        n_checks++; if (if0.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", if0.stall); end
        n_checks++; if (if0.fwd_sel[3:2] !== 2'd0) begin n_fail++; $display("FAIL lu_fwd: got %0d expected 0", if0.fwd_sel[3:2]); end
        tick();
        drive(0, 1, {5'd0, 5'd6, 5'd0}, 3'b010, 0, 0, 0, 0);
        n_checks++; if (if0.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b expected 0", if0.stall); end
        n_checks++; if (if0.fwd_sel[3:2] !== 2'd2) begin n_fail++; $display("FAIL lu_fwd2: got %0d expected 2", if0.fwd_sel[3:2]); end
        n_checks++; if (if0.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", if0.stall_cnt); end
        tick();
        // both operands on the same load: one stall only
        drive(0, 1, '0, 0, 8, 1, 1, 0);
        tick();
        drive(0, 1, {5'd0, 5'd8, 5'd8}, 3'b011, 0, 0, 0, 0);
        n_checks++; if (if0.stall !== 1'b1) begin n_fail++; $display("FAIL lu2_stall: got %b expected 1", if0.stall); end
        tick();
        drive(0, 1, {5'd0, 5'd8, 5'd8}, 3'b011, 0, 0, 0, 0);
        n_checks++; if (if0.fwd_sel !== 4'b1010 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL lu2_fwd: got %b/%b expected 1010/0", if0.fwd_sel, if0.stall); end
        n_checks++; if (if0.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu2_cnt: got %0d expected 2", if0.stall_cnt); end
        tick();
    endtask

    task automatic test_priority();
        drive(0, 1, '0, 0, 7, 1, 0, 0); tick();
        drive(0, 1, '0, 0, 7, 1, 0, 0); tick();
        drive(0, 1, {10'd0, 5'd7}, 3'b001, 0, 0, 0, 0);
        n_checks++; if (if0.fwd_sel[1:0] !== 2'd1) begin n_fail++; $display("FAIL prio_young: got %0d expected 1", if0.fwd_sel[1:0]); end
        tick();
        // youngest is a not-yet-ready load: stall rather than use the older add
        drive(0, 1, '0, 0, 7, 1, 0, 0); tick();
        drive(0, 1, '0, 0, 7, 1, 1, 0); tick();
        drive(0, 1, {10'd0, 5'd7}, 3'b001, 0, 0, 0, 0);
        n_checks++; if (if0.stall !== 1'b1 || if0.fwd_sel[1:0] !== 2'd0) begin n_fail++; $display("FAIL prio_load: got %b/%0d expected 1/0", if0.stall, if0.fwd_sel[1:0]); end
        tick();
        drive(0, 1, {10'd0, 5'd7}, 3'b001, 0, 0, 0, 0);
        n_checks++; if (if0.stall !== 1'b0 || if0.fwd_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL prio_load2: got %b/%0d expected 0/2", if0.stall, if0.fwd_sel[1:0]); end
        n_checks++; if (if0.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL prio_cnt: got %0d expected 3", if0.stall_cnt); end
        tick();
        drive(0, 1, '0, 0, 0, 1, 0, 0); tick();
        drive(0, 1, 15'd0, 3'b001, 0, 0, 0, 0);
        n_checks++; if (if0.fwd_sel[1:0] !== 2'd0) begin n_fail++; $display("FAIL prio_x0: got %0d expected 0", if0.fwd_sel[1:0]); end
        tick();
        drive(0, 1, '0, 0, 7, 1, 0, 0); tick();
        drive(0, 1, {5'd0, 5'd7, 5'd7}, 3'b010, 0, 0, 0, 0);
        n_checks++; if (if0.fwd_sel !== 4'b0100) begin n_fail++; $display("FAIL prio_en: got %b expected 0100", if0.fwd_sel); end
        tick();
    endtask

    task automatic test_flush();
        drive(0, 1, '0, 0, 6, 1, 1, 0); tick();
        drive(0, 1, {5'd0, 5'd6, 5'd0}, 3'b010, 0, 0, 0, 1);
        n_checks++; if (if0.stall !== 1'b0 || if0.fwd_sel[3:2] !== 2'd0) begin n_fail++; $display("FAIL flush_hz: got %b/%0d expected 0/0", if0.stall, if0.fwd_sel[3:2]); end
        tick();
        drive(0, 0, '0, 0, 0, 0, 0, 0);
        n_checks++; if (if0.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 3", if0.stall_cnt); end
        tick();
        drive(0, 1, '0, 0, 10, 1, 1, 1); tick();
        for (int t = 0; t < 2; t++) begin
            drive(0, 1, {5'd0, 5'd10, 5'd10}, 3'b011, 0, 0, 0, 0);
            n_checks++; if (if0.fwd_sel !== 4'd0 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL flush_killed%0d: got %b/%b expected 0000/0", t, if0.fwd_sel, if0.stall); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 3; t++) begin drive(0, 1, '0, 0, 9, 1, 0, 0); tick(); end
        rstn0 = 1'b0;
        drive(0, 1, '0, 0, 9, 1, 0, 0);
        tick();
        rstn0 = 1'b1;
        drive(0, 1, {5'd0, 5'd9, 5'd9}, 3'b011, 0, 0, 0, 0);
        n_checks++; if (if0.fwd_sel !== 4'd0 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL rmid_fwd: got %b/%b expected 0000/0", if0.fwd_sel, if0.stall); end
        n_checks++; if (if0.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d expected 0", if0.stall_cnt); end
        tick();
    endtask

    task automatic test_sweep();
        drive(1, 1, '0, 0, 3, 1, 1, 0); tick();
        for (int t = 0; t < 2; t++) begin
            drive(1, 1, {5'd3, 10'd0}, 3'b100, 0, 0, 0, 0);
            n_checks++; if (if1.stall !== 1'b1 || if1.fwd_sel[8:6] !== 3'd0) begin n_fail++; $display("FAIL sweep_stall%0d: got %b/%0d expected 1/0", t, if1.stall, if1.fwd_sel[8:6]); end
            tick();
        end
        drive(1, 1, {5'd3, 10'd0}, 3'b100, 0, 0, 0, 0);
        n_checks++; if (if1.stall !== 1'b0 || if1.fwd_sel[8:6] !== 3'd3) begin n_fail++; $display("FAIL sweep_fwd: got %b/%0d expected 0/3", if1.stall, if1.fwd_sel[8:6]); end
        n_checks++; if (if1.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL sweep_cnt: got %0d expected 2", if1.stall_cnt); end
        tick();
    endtask

    task automatic test_random(input int inst, input int n);
        bit        prev = 1'b0;
        bit        v, we, ld, fl;
        bit [14:0] rs;
        bit [2:0]  en;
        bit [4:0]  rd;
        bit [8:0]  es;
        bit        est;
        bit [2:0]  act;
        int        ns;
        ns = (inst == 0) ? 2 : 3;
        for (int c = 0; c < n; c++) begin
            if (!prev) begin
                v  = ($urandom_range(0, 99) < 85);
                rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
                en = 3'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 3));
                we = ($urandom_range(0, 3) != 0);
                ld = ($urandom_range(0, 2) == 0);
                fl = ($urandom_range(0, 9) == 0);
            end
            drive(inst, v, rs, en, rd, we, ld, fl);
            model_eval(inst, es, est);
            for (int i = 0; i < ns; i++) begin
                act = (inst == 0) ? 3'(if0.fwd_sel[2*i +: 2]) : if1.fwd_sel[3*i +: 3];
                n_checks++; if (act !== es[3*i +: 3]) begin n_fail++; $display("FAIL rnd%0d_fwd op%0d cyc%0d: got %0d expected %0d", inst, i, c, act, es[3*i +: 3]); end
            end
            n_checks++;
            if (((inst == 0) ? if0.stall : if1.stall) !== est) begin
                n_fail++; $display("FAIL rnd%0d_stall cyc%0d: got %b expected %b", inst, c, (inst == 0) ? if0.stall : if1.stall, est);
            end
            n_checks++;
            if (((inst == 0) ? if0.stall_cnt : if1.stall_cnt) !== 16'(cnt_m[inst])) begin
                n_fail++; $display("FAIL rnd%0d_cnt cyc%0d: got %0d expected %0d", inst, c, (inst == 0) ? if0.stall_cnt : if1.stall_cnt, cnt_m[inst]);
            end
            prev = est;
            tick();
        end
    endtask

    // DEPTH=7, LOAD_LAT=6, chained self-dependent loads: 6 stalls every 7 cycles.
    task automatic test_saturation();
        if2.ex_valid = 1'b1; if2.ex_rs = 5'd3; if2.ex_rs_en = 1'b1; if2.ex_rd = 5'd3;
        if2.ex_we = 1'b1; if2.ex_is_load = 1'b1; if2.flush = 1'b0;
        rstn2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn2 = 1'b1;
        repeat (700) @(posedge clk);
        @(negedge clk);
        n_checks++; if (if2.stall_cnt !== 16'd600) begin n_fail++; $display("FAIL sat_ratio: got %0d expected 600", if2.stall_cnt); end
        repeat (76454 - 700) @(posedge clk);
        @(negedge clk);
        n_checks++; if (if2.stall_cnt !== 16'hFFFC) begin n_fail++; $display("FAIL sat_near: got %h expected fffc", if2.stall_cnt); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++; if (if2.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit: got %h expected ffff", if2.stall_cnt); end
        repeat (14) @(posedge clk);
        @(negedge clk);
        n_checks++; if (if2.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", if2.stall_cnt); end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_forward();
                test_load_use();
                test_priority();
                test_flush();
                test_reset_mid();
                test_random(0, 300);
                test_sweep();
                test_random(1, 300);
            end
            test_saturation();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Parametrised forwarding and load-use interlock unit for the EX stage of the in-order RV pipeline. It keeps its own shift register of in-flight writers (rd, write-enable, load flag) for the stages after EX, so upstream stages no longer present their instruction words. Each cycle it drives, per source operand, the bypass source for EX and a single pipeline stall. Depth, load latency and source-operand count are configurable, and it keeps a saturating stall counter for performance analysis.

## Interface
- NUM_SRC, 2: source operands per instruction (1..3).
- DEPTH, 3: tracked stages after EX; slot 1 = MEM, slot 2 = WB, slot 3 = WB_temp (2..7).
- LOAD_LAT, 1: a load result becomes forwardable only from slot LOAD_LAT+1 (0..DEPTH-1).
- SW, derived = $clog2(DEPTH+1): width of one select field.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous, active-low reset
- ex_valid  in  1  EX holds a live instruction
- ex_rs  in  5*NUM_SRC  source register indices; operand i at [5i+4:5i]
- ex_rs_en  in  NUM_SRC  operand i actually reads a register
- ex_rd  in  5  destination register
- ex_we  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- flush  in  1  kill the EX instruction this cycle
- fwd_sel  out  SW*NUM_SRC  per operand: 0 = register file, k = slot k
- stall  out  1  hold IF/ID/EX and insert a bubble into slot 1
- stall_cnt  out  16  stalled cycles since reset, saturating

## Operation
- Slot k holds {v, rd, we, ld}. "Writer match" for operand i at slot k means: v & we & rd!=0 & rd==rs_i & ex_rs_en[i].
- Per operand, select the youngest matching slot, i.e. the smallest k.
  - No match -> fwd_sel_i = 0.
  - Match at k, not a load -> fwd_sel_i = k.
  - Match at k, load, k > LOAD_LAT -> fwd_sel_i = k.
  - Match at k, load, k <= LOAD_LAT -> hazard_i = 1 and fwd_sel_i = 0. An older slot is never used in place of the youngest one.
- stall = ex_valid & ~flush & OR(hazard_i).
- If ex_valid=0 or flush=1, fwd_sel is still computed but stall=0.
- Slot update on each rising edge, when rstn=1:
  - slot[k+1] <= slot[k] for k = 1..DEPTH-1.
  - Slot DEPTH is discarded.
  - slot[1] <= {ex_valid & ~flush & ~stall, ex_rd, ex_we, ex_is_load}.
  - While stalled, slot 1 therefore receives a bubble. EX inputs stay constant because upstream holds.
- stall_cnt increments on each clock where stall=1 and saturates at 16'hFFFF.
- Reset (rstn=0 at an edge):
  - All slot v = 0, stall_cnt = 0.
  - As a consequence, fwd_sel = 0 and stall = 0 in the cycle after reset.
  - Applies mid-operation too: in-flight writers are dropped and no forward is issued from them.

## Timing
- fwd_sel and stall are combinational from current slot state and EX inputs, valid in the same cycle. There are no registered outputs except stall_cnt.
- Slot shift latency: one cycle per stage. A writer entering EX at cycle t occupies slot k at cycle t+k.
- A load followed by a dependent instruction stalls for exactly LOAD_LAT cycles (with no intervening flush). It then forwards from slot LOAD_LAT+1.
- Multiple operands hitting the same load produce one stall, not additive stalls.
- flush and hazard in the same cycle: flush wins. stall=0, a bubble is inserted and stall_cnt is unchanged.
- Simultaneous matches in several slots: the youngest wins, including the case where the youngest is a stalling load.

## Test plan
- Default parameters: `add x5` in EX at t; at t+1 an instruction with rs1=x5, rs2=x5 -> fwd_sel = {2'd1, 2'd1}, stall=0. At t+2 (intervening nop) -> fwd_sel=2; at t+3 -> 3; at t+4 -> 0.
- Load-use: `lw x6` at t; dependent rs2=x6 at t+1 -> stall=1, fwd_sel_1=0 at t+1. At t+2 -> stall=0, fwd_sel_1=2, stall_cnt=1.
- Priority: `add x7` at t, `add x7` at t+1; reader of x7 at t+2 -> fwd_sel_0=1. Also a writer with rd=x0 matched by rs1=x0 -> fwd_sel_0=0. Also ex_rs_en[0]=0 -> fwd_sel_0=0.
- Flush: load-use hazard pending with flush=1 -> stall=0, slot 1 receives a bubble, stall_cnt unchanged. The next reader of that register gets no forward from the flushed load.
- Reset mid-stream: fill all slots with writers to x9, assert rstn=0 for one edge -> following cycle, reader of x9 gets fwd_sel=0, stall=0, stall_cnt=0.
- Parameter sweep with DEPTH=4, LOAD_LAT=2, NUM_SRC=3: `lw x3` then a reader of x3 -> stall for exactly 2 cycles, then fwd_sel=3. Separately, force 70000 stall cycles -> stall_cnt holds at 16'hFFFF.
